// File: rtl/urx_pkg.sv
// Shared definitions for the host-link UART receiver (and the future transmitter).
package urx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } urx_state_t;

    localparam int URX_DATA_BITS = 8;

    function automatic logic urx_parity(input logic [URX_DATA_BITS-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/urx_rcv_if.sv
// Received-byte bus from the UART receiver to the command decoder.
// rx_vld is a one-cycle strobe with no ready: rx_data/rx_perr/rx_ferr are valid only in the
// rx_vld cycle, and the consumer must take the byte before the next strobe overwrites rx_data.
interface urx_rcv_if;
    logic [7:0] rx_data;
    logic       rx_vld;
    logic       rx_perr;
    logic       rx_ferr;
    logic       rx_busy;

    modport master (output rx_data, rx_vld, rx_perr, rx_ferr, rx_busy);
    modport slave  (input  rx_data, rx_vld, rx_perr, rx_ferr, rx_busy);
endinterface

// File: rtl/urx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle level (1).
module urx_sync (
    input  logic clk_sys,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_q;

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_q    <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/urx_rcv.sv
// UART receiver: 1 start, 8 data MSB first, XOR parity, 1 stop; mid-bit sampling
// driven by a down-counter, one-cycle strobe per completed frame.
module urx_rcv
    import urx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic       uart_rx,
    urx_rcv_if.master  rx_if,
    output urx_state_t dbg_state
);
    localparam int             CW       = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0]  CNT_FULL = CW'(CLKS_PER_BIT);
    localparam logic [CW-1:0]  CNT_HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [2:0]     LAST_BIT = 3'(URX_DATA_BITS - 1);

    logic                     w_rxs;
    logic                     w_expire;
    urx_state_t               r_state;
    logic [CW-1:0]            r_cnt;
    logic [2:0]               r_bit_cnt;
    logic [URX_DATA_BITS-1:0] r_shift;
    logic                     r_perr_pend;
    logic [7:0]               r_data;
    logic                     r_vld;
    logic                     r_perr;
    logic                     r_ferr;
    logic                     r_busy;

    urx_sync u_sync (
        .clk_sys (clk_sys),
        .rst     (rst),
        .i_d     (uart_rx),
        .o_q     (w_rxs)
    );

    // The counter is loaded with the interval to the next sample; value 1 marks the sample cycle.
    assign w_expire = (r_cnt == CW'(1));

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_perr_pend <= 1'b0;
            r_data      <= '0;
            r_vld       <= 1'b0;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_vld  <= 1'b0;
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
            r_busy <= 1'b1;
            if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
            case (r_state)
                IDLE: begin
                    if (!w_rxs) begin
                        r_cnt   <= CNT_HALF;
                        r_state <= START;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                START: begin
                    if (w_expire) begin
                        if (w_rxs) begin
                            r_state <= IDLE;
                        end else begin
                            r_cnt     <= CNT_FULL;
                            r_bit_cnt <= '0;
                            r_state   <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_expire) begin
                        r_shift <= {r_shift[URX_DATA_BITS-2:0], w_rxs};
                        r_cnt   <= CNT_FULL;
                        if (r_bit_cnt == LAST_BIT) r_state <= PARITY;
                        else r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                end
                PARITY: begin
                    if (w_expire) begin
                        r_perr_pend <= urx_parity(r_shift) ^ w_rxs;
                        r_cnt       <= CNT_FULL;
                        r_state     <= STOP;
                    end
                end
                STOP: begin
                    // Leave mid stop bit so a start bit right after it is not missed.
                    if (w_expire) begin
                        r_data  <= r_shift;
                        r_perr  <= r_perr_pend;
                        r_ferr  <= ~w_rxs;
                        r_vld   <= 1'b1;
                        r_state <= w_rxs ? IDLE : BREAK;
                    end
                end
                BREAK: begin
                    if (w_rxs) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rx_if.rx_data = r_data;
    assign rx_if.rx_vld  = r_vld;
    assign rx_if.rx_perr = r_perr;
    assign rx_if.rx_ferr = r_ferr;
    assign rx_if.rx_busy = r_busy;
    assign dbg_state     = r_state;
endmodule
